ex_muldiv: RTL and testbench

Multi-cycle M-extension execution unit in the EX pipe stage. It consumes the 4-bit ALUOp produced by ALU control for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, together with the forwarded operands. It computes the result over several cycles while holding `busy` so the hazard unit stalls the pipeline, then returns the 32-bit result with a one-cycle `done` pulse.

---
 rtl/ex_muldiv.sv | 128 ++++++++++++
 tb/tb_ex_muldiv.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit for the EX pipe stage
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, alu_op       request and ALUOp code (MUL..REMU), sampled only in IDLE
//   op_a, op_b          rs1/rs2 operands, latched on accept
//   kill                pipeline flush, aborts any operation without done
//   busy                operation in flight (EX stall request)
//   done, result        one-cycle completion pulse and result held until the next completion
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [3:0] OP_MUL    = 4'd8;
    localparam logic [3:0] OP_MULH   = 4'd9;
    localparam logic [3:0] OP_MULHSU = 4'd10;
    localparam logic [3:0] OP_MULHU  = 4'd11;
    localparam logic [3:0] OP_DIV    = 4'd12;
    localparam logic [3:0] OP_DIVU   = 4'd13;
    localparam logic [3:0] OP_REM    = 4'd14;
    localparam logic [3:0] OP_REMU   = 4'd15;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_nx;

    // a_q doubles as the dividend/quotient shift register during DIV;
    // sa_q/sb_q mean "operand is negative under this op's signedness".
    logic [3:0]      op_q;
    logic            sa_q, sb_q, fixd;
    logic [5:0]      cnt;
    logic [XLEN-1:0] a_q, b_q, rem, val;

    logic            is_m, is_mul, is_rem, a_neg, b_neg, special, accept, finish, neg;
    logic [XLEN-1:0] spec_val, mag_a, mag_b, diff;
    logic [XLEN:0]   sh;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        is_m     = alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_mul   = alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        is_rem   = alu_op inside {OP_REM, OP_REMU};
        a_neg    = (alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a[XLEN-1];
        b_neg    = (alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
        special  = !is_mul && (op_b == '0 ||
                   ((alu_op inside {OP_DIV, OP_REM}) && op_a == INT_MIN && op_b == '1));
        spec_val = is_rem ? (op_b == '0 ? op_a : '0) : (op_b == '0 ? '1 : INT_MIN);
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        accept   = state == IDLE && start && !kill && is_m;
        finish   = state == FIX && fixd && !kill;
        // one restoring step: shift in the next dividend bit, subtract if it fits
        sh       = {rem, a_q[XLEN-1]};
        neg      = sh < {1'b0, b_q};
        diff     = sh[XLEN-1:0] - b_q;
        // low 2*XLEN bits of the 33x33 signed product
        prod     = {{XLEN{sa_q}}, a_q} * {{XLEN{sb_q}}, b_q};
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Special-case divides and products park in FIX with fixd set, so FIX
    // is the single place that raises done; divides spend one FIX cycle
    // applying signs before that.
    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        case (state)
            IDLE: if (accept) state_nx = special ? FIX : (is_mul ? MUL : DIV);
            MUL:  state_nx = FIX;
            DIV:  if (cnt == 6'd31) state_nx = FIX;
            FIX:  if (fixd) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            fixd   <= 1'b0;
        end else begin
            done <= finish;
            if (finish) result <= val;
            if (accept) begin
                op_q <= alu_op;
                sa_q <= a_neg;
                sb_q <= b_neg;
                a_q  <= is_mul ? op_a : mag_a;
                b_q  <= is_mul ? op_b : mag_b;
                rem  <= '0;
                cnt  <= '0;
                fixd <= special;
                val  <= spec_val;
            end
            if (state == MUL) begin
                val  <= op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                fixd <= 1'b1;
            end
            if (state == DIV) begin
                a_q <= {a_q[XLEN-2:0], !neg};
                rem <= neg ? sh[XLEN-1:0] : diff;
                cnt <= cnt + 6'd1;
            end
            if (state == FIX && !fixd) begin
                val  <= (op_q inside {OP_REM, OP_REMU}) ? (sa_q ? -rem : rem)
                                                       : ((sa_q ^ sb_q) ? -a_q : a_q);
                fixd <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    localparam logic [3:0] ADD    = 4'd0;
    localparam logic [3:0] MUL    = 4'd8;
    localparam logic [3:0] MULH   = 4'd9;
    localparam logic [3:0] MULHSU = 4'd10;
    localparam logic [3:0] MULHU  = 4'd11;
    localparam logic [3:0] DIV    = 4'd12;
    localparam logic [3:0] DIVU   = 4'd13;
    localparam logic [3:0] REM    = 4'd14;
    localparam logic [3:0] REMU   = 4'd15;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          dn;
        bit          killed;
        bit          rst;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } dir_t;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, kill = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int          cyc = 0, errors = 0, checks = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_res = '0;
    exp_t        q[$];
    exp_t        me;
    bit          bexp;

    logic [3:0]  ops[8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    dir_t dir[14] = '{
        '{MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 2},
        '{MULH,   32'h80000000,   32'h80000000, 32'h40000000, 2},
        '{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 2},
        '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 2},
        '{DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34},
        '{REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34},
        '{DIVU,   32'd100,        32'd7,        32'd14,       34},
        '{REMU,   32'd100,        32'd7,        32'd2,        34},
        '{DIV,    32'h1234,       32'd0,        32'hFFFFFFFF, 1},
        '{DIVU,   32'h1234,       32'd0,        32'hFFFFFFFF, 1},
        '{REM,    32'h1234,       32'd0,        32'h1234,     1},
        '{REMU,   32'h1234,       32'd0,        32'h1234,     1},
        '{DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1},
        '{REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1}
    };

    ex_muldiv #(.XLEN(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .alu_op (alu_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, za, zb, p;
        int ia, ib;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        za  = longint'({32'b0, a});
        zb  = longint'({32'b0, b});
        ia  = a;
        ib  = b;
        ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
        case (op)
            MUL:    begin p = sa * sb; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * zb; return p[63:32]; end
            MULHU:  begin p = za * zb; return p[63:32]; end
            DIV:    return b == 0 ? 32'hFFFFFFFF : (ovf ? 32'h80000000 : 32'(ia / ib));
            REM:    return b == 0 ? a : (ovf ? 32'd0 : 32'(ia % ib));
            DIVU:   return b == 0 ? 32'hFFFFFFFF : a / b;
            REMU:   return b == 0 ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {MUL, MULH, MULHSU, MULHU}) return 2;
        if (b == 0 || ((op == DIV || op == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // waits for IDLE, so an op issued in a done cycle is accepted back-to-back
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int lat);
        int n = 0;
        exp_t e;
        while (busy && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
        end
        start  = 1'b1;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        e.res = want; e.acc = cyc + 1; e.dn = cyc + 1 + lat; e.killed = 1'b0; e.rst = 1'b0;
        q.push_back(e);
        step();
        start  = 1'b0;
        alu_op = 4'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic abort(input bit by_reset);
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        e.dn = cyc + 1;
        e.killed = 1'b1;
        e.rst = by_reset;
        q.push_front(e);
        if (by_reset) reset = 1'b1;
        else kill = 1'b1;
        step();
        reset = 1'b0;
        kill  = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            bexp = q.size() > 0 && cyc >= q[0].acc && cyc < q[0].dn;
            chk("busy", 32'(busy), 32'(bexp));
            if (q.size() > 0 && cyc == q[0].dn) begin
                me = q.pop_front();
                chk("done", 32'(done), me.killed ? 32'd0 : 32'd1);
                if (!me.killed) begin
                    chk("result", result, me.res);
                    exp_res = me.res;
                end else if (me.rst) begin
                    exp_res = '0;
                end
            end else begin
                chk("no_done", 32'(done), 32'd0);
            end
            if (!done) chk("hold", result, exp_res);
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int n;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        step();
        step();
        start = 1'b1; alu_op = ADD; op_a = 32'd5; op_b = 32'd6;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; kill = 1'b1; alu_op = MUL; op_a = 32'd3; op_b = 32'd5;
        step();
        start = 1'b0; kill = 1'b0;
        step();
        step();
        foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].r, dir[i].lat);
        issue(DIVU, 32'd100, 32'd7, 32'd14, 34);
        repeat (5) step();
        start = 1'b1; alu_op = MUL; op_a = 32'd3; op_b = 32'd3;
        step();
        start = 1'b0;
        issue(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        repeat (10) step();
        abort(1'b0);
        issue(MUL, 32'd3, 32'd5, 32'd15, 2);
        issue(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        repeat (10) step();
        abort(1'b1);
        issue(MUL, 32'd3, 32'd5, 32'd15, 2);
        issue(DIV, 32'd1000, 32'd9, 32'd111, 34);
        issue(MUL, 32'd6, 32'd7, 32'd42, 2);
        repeat (40) begin
            op = ops[$urandom_range(0, 7)];
            a  = pick();
            b  = pick();
            issue(op, a, b, model(op, a, b), lat_of(op, a, b));
        end
        n = 0;
        while (q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d operations never completed", q.size());
        end
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
